// File: rtl/dino_pkg.sv
// Shared types and helpers for the dino game sequencer.
package dino_pkg;

    // Sequencer states; PAUSED is only reachable when DINO_PAUSE_EN is defined.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        OVER    = 2'b10,
        PAUSED  = 2'b11
    } game_state_t;

    localparam int SCORE_W_DEF = 16;

    // Clock cycles per frame tick.
    function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/dino_game_ctrl_if.sv
// Link between the game sequencer (master) and the score counter (slave).
// game_start, game_over and game_tick are single-cycle pulses with no back-pressure:
// the counter must act on every cycle a pulse is high. score_in is a plain level
// that the sequencer samples in the cycle its game_over pulse is high.
interface dino_game_ctrl_if
    import dino_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
);
    logic               game_start;
    logic               game_over;
    logic               game_tick;
    logic [SCORE_W-1:0] score_in;

    modport master (output game_start, output game_over, output game_tick, input score_in);
    modport slave  (input game_start, input game_over, input game_tick, output score_in);
endinterface

// File: rtl/dino_tick_div.sv
// Frame divider: counts 0..DIV-1 while enabled; tc flags the last count of a frame.
module dino_tick_div #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);

    logic [CW-1:0] count;

    assign tc = en && (count == CW'(DIV - 1));

    // Divider counter: clear has priority, otherwise advance and wrap while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == CW'(DIV - 1)) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dino_game_ctrl.sv
// Game sequencer: turns button/collision levels into start/over/tick pulses,
// runs the frame divider, enforces the post-game start lockout and keeps the
// session high score. Optional macro DINO_PAUSE_EN adds a pause input and PAUSED state.
module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TICK_HZ       = 60,
    parameter int SCORE_W       = SCORE_W_DEF,
    parameter int LOCKOUT_TICKS = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_start,
    input  logic               collision,
`ifdef DINO_PAUSE_EN
    input  logic               pause,
`endif
    dino_game_ctrl_if.master   bus,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high
);
    localparam int TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
    localparam int LW       = (LOCKOUT_TICKS < 1) ? 1 : $clog2(LOCKOUT_TICKS + 1);

    game_state_t  cur_state;
    game_state_t  nxt_state;
    logic         primed;
    logic         btn_q;
    logic         start_edge;
    logic         pause_edge;
    logic         start_nxt;
    logic         over_nxt;
    logic         tick_nxt;
    logic         div_clr;
    logic         div_en;
    logic         tc;
    logic [LW-1:0] lockout;
    logic         start_q;
    logic         over_q;
    logic         tick_q;

    // The first cycle after reset only loads the edge registers, so a button held
    // through reset is seen as already high and cannot start a game.
    assign start_edge = primed && btn_start && !btn_q;

`ifdef DINO_PAUSE_EN
    logic pause_q;
    assign pause_edge = primed && pause && !pause_q;

    // Pause edge register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause;
        end
    end
`else
    assign pause_edge = 1'b0;
`endif

    // Button edge register and post-reset priming flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed <= 1'b0;
            btn_q  <= 1'b0;
        end else begin
            primed <= 1'b1;
            btn_q  <= btn_start;
        end
    end

    assign div_en = (cur_state == RUNNING) || (cur_state == OVER);

    dino_tick_div #(.DIV(TICK_DIV)) u_tick_div (
        .clk (clk),
        .rst (rst),
        .clr (div_clr),
        .en  (div_en),
        .tc  (tc)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // FSM next state and next-cycle pulse requests.
    always_comb begin
        nxt_state = cur_state;
        start_nxt = 1'b0;
        over_nxt  = 1'b0;
        tick_nxt  = 1'b0;
        div_clr   = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start_edge) begin
                    nxt_state = RUNNING;
                    start_nxt = 1'b1;
                    div_clr   = 1'b1;
                end
            end
            RUNNING: begin
                if (collision) begin
                    nxt_state = OVER;
                    over_nxt  = 1'b1;
                end else begin
                    tick_nxt = tc;
                    if (pause_edge) begin
                        nxt_state = PAUSED;
                    end
                end
            end
            OVER: begin
                if (start_edge && (lockout == '0)) begin
                    nxt_state = RUNNING;
                    start_nxt = 1'b1;
                    div_clr   = 1'b1;
                end
            end
`ifdef DINO_PAUSE_EN
            PAUSED: begin
                if (pause_edge) begin
                    nxt_state = RUNNING;
                end
            end
`endif
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            over_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            start_q <= start_nxt;
            over_q  <= over_nxt;
            tick_q  <= tick_nxt;
        end
    end

    // Lockout: loaded on game over, counts frame wraps down while OVER.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockout <= '0;
        end else if (over_nxt) begin
            lockout <= LW'(LOCKOUT_TICKS);
        end else if ((cur_state == OVER) && tc && (lockout != '0)) begin
            lockout <= lockout - LW'(1);
        end
    end

    // High score: sample score_in during the game_over pulse; a new game clears new_high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_score <= '0;
            new_high   <= 1'b0;
        end else begin
            if (over_q && (bus.score_in > high_score)) begin
                high_score <= bus.score_in;
                new_high   <= 1'b1;
            end
            if (start_nxt) begin
                new_high <= 1'b0;
            end
        end
    end

    assign bus.game_start = start_q;
    assign bus.game_over  = over_q;
    assign bus.game_tick  = tick_q;
    assign state          = cur_state;

endmodule
